// File: rtl/mem_dbus_stage_pkg.sv
// mem_dbus_stage_pkg: shared widths, opcodes, FSM encoding and op classifiers for the MEM stage.
package mem_dbus_stage_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus = 8;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LH_OP = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_LW_OP = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_SB_OP = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP = 8'b1110_1011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  function automatic logic is_load(input logic [AluOpBus-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  function automatic logic is_store(input logic [AluOpBus-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_mem(input logic [AluOpBus-1:0] op);
    return is_load(op) | is_store(op);
  endfunction
  function automatic logic is_byte(input logic [AluOpBus-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  endfunction
  function automatic logic is_half(input logic [AluOpBus-1:0] op);
    return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  endfunction
  function automatic logic misaligned(input logic [AluOpBus-1:0] op, input logic [1:0] a);
    return (is_half(op) & a[0]) | ((op == EXE_LW_OP || op == EXE_SW_OP) & (a != 2'b00));
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane selects, replicated store data and extended load data.
module mem_lane_align
  import mem_dbus_stage_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr,
  input  logic [RegBus-1:0]   reg2,
  input  logic [RegBus-1:0]   rdata,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   sdat,
  output logic [RegBus-1:0]   ldat
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = addr == 2'd0 ? rdata[31:24] : addr == 2'd1 ? rdata[23:16] : addr == 2'd2 ? rdata[15:8] : rdata[7:0];
    h = addr[1] ? rdata[15:0] : rdata[31:16];
    sel = is_byte(aluop) ? 4'b1000 >> addr : is_half(aluop) ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    sdat = is_byte(aluop) ? {4{reg2[7:0]}} : is_half(aluop) ? {2{reg2[15:0]}} : reg2;
    ldat = aluop == EXE_LB_OP ? {{24{b[7]}}, b} :
           aluop == EXE_LBU_OP ? {24'b0, b} :
           aluop == EXE_LH_OP ? {{16{h[15]}}, h} :
           aluop == EXE_LHU_OP ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_dbus_stage.sv
// mem_dbus_stage: MEM pipeline stage driving loads/stores over a Wishbone-style data bus.
module mem_dbus_stage
  import mem_dbus_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall_i,
  input  logic                  flush_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegBus-1:0]     dbus_dat_i,
  input  logic                  dbus_ack_i,
  output logic [RegBus-1:0]     dbus_adr_o,
  output logic [RegBus-1:0]     dbus_dat_o,
  output logic                  dbus_we_o,
  output logic [3:0]            dbus_sel_o,
  output logic                  dbus_stb_o,
  output logic                  dbus_cyc_o,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o,
  output logic                  misalign_o
);
  logic [1:0] state, nxt;
  logic [RegBus-1:0] rdata, ldat, sdat;
  logic [3:0] sel;
  logic mem, mis, hold, acc, done, unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};
  assign mem = is_mem(aluop_i);
  assign mis = mem & misaligned(aluop_i, mem_addr_i[1:0]);
  assign hold = state == S_HOLD;
  // The EX/MEM register is frozen while we stall, so IDLE and BUSY drive the bus from the same inputs.
  assign acc = !rst & mem & !mis & !hold;
  assign done = acc & dbus_ack_i & !flush_i;
  assign nxt = flush_i ? S_IDLE :
               hold ? (stall_i[4] ? S_HOLD : S_IDLE) :
               acc ? (!dbus_ack_i ? S_BUSY : stall_i[4] ? S_HOLD : S_IDLE) : S_IDLE;
  mem_lane_align u_align (
    .aluop(aluop_i),
    .addr (mem_addr_i[1:0]),
    .reg2 (reg2_i),
    .rdata(hold ? rdata : dbus_dat_i),
    .sel  (sel),
    .sdat (sdat),
    .ldat (ldat)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rdata <= '0;
    end else begin
      state <= nxt;
      if (done) rdata <= dbus_dat_i;
    end
  end
  always_comb begin
    stallreq_o = acc & !dbus_ack_i & !flush_i;
    dbus_cyc_o = acc;
    dbus_stb_o = acc;
    dbus_we_o = acc & is_store(aluop_i);
    dbus_sel_o = acc ? sel : 4'b0;
    dbus_adr_o = acc ? {mem_addr_i[31:2], 2'b00} : '0;
    dbus_dat_o = dbus_we_o ? sdat : '0;
    misalign_o = !rst & mis & !hold;
    wd_o = rst ? '0 : wd_i;
    wreg_o = !rst & !flush_i & wreg_i & !mis & !stallreq_o;
    wdata_o = rst ? '0 : (is_load(aluop_i) & (done | hold)) ? ldat : wdata_i;
    hi_o = rst ? '0 : hi_i;
    lo_o = rst ? '0 : lo_i;
    whilo_o = !rst & whilo_i;
  end
endmodule

// File: tb/tb_mem_dbus_stage.sv
// tb_mem_dbus_stage: vector table, directed multi-cycle sequences and random transactions vs a reference model.
module tb_mem_dbus_stage;
  import mem_dbus_stage_pkg::*;
  logic clk = 0, rst, flush_i, wreg_i, whilo_i, dbus_ack_i;
  logic [5:0] stall_i;
  logic [4:0] wd_i;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, dbus_dat_i;
  logic [7:0] aluop_i;
  logic [31:0] dbus_adr_o, dbus_dat_o, wdata_o, hi_o, lo_o;
  logic dbus_we_o, dbus_stb_o, dbus_cyc_o, wreg_o, whilo_o, stallreq_o, misalign_o;
  logic [3:0] dbus_sel_o;
  logic [4:0] wd_o;
  int n_chk = 0, n_fail = 0;

  mem_dbus_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i),
    .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o), .dbus_we_o(dbus_we_o), .dbus_sel_o(dbus_sel_o),
    .dbus_stb_o(dbus_stb_o), .dbus_cyc_o(dbus_cyc_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [31:0] adr, r2, din;
    logic wr;
    logic [3:0] sel;
    logic [31:0] dout;
    logic we;
    logic [31:0] wdata;
    logic mis;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] r2, input logic wr, input logic [31:0] wd);
    aluop_i = op; mem_addr_i = adr; reg2_i = r2; wreg_i = wr; wdata_i = wd;
  endtask

  task automatic idle;
    drv(EXE_NOP_OP, 0, 0, 0, 0);
    dbus_ack_i = 0; flush_i = 0; stall_i = 0;
    #2;
    chk("idle_cyc", dbus_cyc_o, 0);
    step();
  endtask

  function automatic logic m_load_op(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction
  function automatic int m_size(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction
  function automatic logic m_mis(input logic [7:0] op, input logic [31:0] adr);
    return (adr % m_size(op)) != 0;
  endfunction
  function automatic logic [31:0] m_sel(input logic [7:0] op, input logic [31:0] adr);
    int a = int'(adr % 4);
    if (m_size(op) == 1) return 32'(1 << (3 - a));
    if (m_size(op) == 2) return a >= 2 ? 32'd3 : 32'd12;
    return 32'd15;
  endfunction
  function automatic logic [31:0] m_sdat(input logic [7:0] op, input logic [31:0] r2);
    if (m_size(op) == 1) return (r2 % 256) * 32'h0101_0101;
    if (m_size(op) == 2) return (r2 % 65536) * 32'h0001_0001;
    return r2;
  endfunction
  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] d);
    int a = int'(adr % 4);
    logic [31:0] bv, hv;
    bv = (d >> (8 * (3 - a))) % 256;
    hv = (d >> (a >= 2 ? 0 : 16)) % 65536;
    if (op == EXE_LB_OP) return bv + (bv >= 128 ? 32'hFFFF_FF00 : 32'h0);
    if (op == EXE_LBU_OP) return bv;
    if (op == EXE_LH_OP) return hv + (hv >= 32768 ? 32'hFFFF_0000 : 32'h0);
    if (op == EXE_LHU_OP) return hv;
    return d;
  endfunction

  logic [7:0] mops [8];
  logic [7:0] pops [4];
  logic [7:0] op;
  logic [31:0] adr, r2, din, wd, exp_w;
  logic ld, st, mis, pass;
  int dly, hc;

  initial begin
    mops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    pops = '{EXE_NOP_OP, 8'h20, 8'h25, 8'h21};
    tbl[0]  = '{EXE_LB_OP,  32'h202, 32'h0, 32'h1122_8344, 1, 4'b0010, 32'h0, 0, 32'hFFFF_FF83, 0};
    tbl[1]  = '{EXE_LBU_OP, 32'h202, 32'h0, 32'h1122_8344, 1, 4'b0010, 32'h0, 0, 32'h0000_0083, 0};
    tbl[2]  = '{EXE_SB_OP,  32'h203, 32'hA5, 32'h0, 0, 4'b0001, 32'hA5A5_A5A5, 1, 32'hCAFE_0000, 0};
    tbl[3]  = '{EXE_LH_OP,  32'h202, 32'h0, 32'h0000_8001, 1, 4'b0011, 32'h0, 0, 32'hFFFF_8001, 0};
    tbl[4]  = '{EXE_LHU_OP, 32'h200, 32'h0, 32'h8001_7FFF, 1, 4'b1100, 32'h0, 0, 32'h0000_8001, 0};
    tbl[5]  = '{EXE_LH_OP,  32'h200, 32'h0, 32'h7FFF_0000, 1, 4'b1100, 32'h0, 0, 32'h0000_7FFF, 0};
    tbl[6]  = '{EXE_SH_OP,  32'h202, 32'h1234_BEEF, 32'h0, 0, 4'b0011, 32'hBEEF_BEEF, 1, 32'hCAFE_0000, 0};
    tbl[7]  = '{EXE_SW_OP,  32'h204, 32'h0102_0304, 32'h0, 0, 4'b1111, 32'h0102_0304, 1, 32'hCAFE_0000, 0};
    tbl[8]  = '{EXE_LB_OP,  32'h200, 32'h0, 32'h80FF_FFFF, 1, 4'b1000, 32'h0, 0, 32'hFFFF_FF80, 0};
    tbl[9]  = '{EXE_LBU_OP, 32'h201, 32'h0, 32'h00FE_0000, 1, 4'b0100, 32'h0, 0, 32'h0000_00FE, 0};
    tbl[10] = '{EXE_LBU_OP, 32'h203, 32'h0, 32'h0000_00AB, 1, 4'b0001, 32'h0, 0, 32'h0000_00AB, 0};
    tbl[11] = '{EXE_LW_OP,  32'h102, 32'h0, 32'h1111_1111, 1, 4'b0000, 32'h0, 0, 32'hCAFE_0000, 1};
    tbl[12] = '{EXE_SH_OP,  32'h201, 32'h55, 32'h0, 0, 4'b0000, 32'h0, 0, 32'hCAFE_0000, 1};
    tbl[13] = '{EXE_LH_OP,  32'h203, 32'h0, 32'h2222_2222, 1, 4'b0000, 32'h0, 0, 32'hCAFE_0000, 1};

    rst = 1; flush_i = 0; stall_i = 0; dbus_ack_i = 0; dbus_dat_i = 0; whilo_i = 1;
    wd_i = 5'd3; hi_i = 32'h1111_0000; lo_i = 32'h0000_2222;
    drv(EXE_LW_OP, 32'h100, 0, 1, 32'h1234_5678);
    step();
    #2;
    chk("rst_cyc", dbus_cyc_o, 0);
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_whilo", whilo_o, 0);
    step();
    rst = 0;
    idle();

    drv(8'h20, 0, 0, 1, 32'h1234_5678); wd_i = 5'd3;
    #2;
    chk("pass_wdata", wdata_o, 32'h1234_5678);
    chk("pass_wreg", wreg_o, 1);
    chk("pass_wd", wd_o, 3);
    chk("pass_hi", hi_o, 32'h1111_0000);
    chk("pass_lo", lo_o, 32'h0000_2222);
    chk("pass_cyc", dbus_cyc_o, 0);
    step();

    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].op, tbl[i].adr, tbl[i].r2, tbl[i].wr, 32'hCAFE_0000);
      dbus_ack_i = 1; dbus_dat_i = tbl[i].din;
      #2;
      chk($sformatf("vec%0d_sel", i), dbus_sel_o, tbl[i].sel);
      chk($sformatf("vec%0d_dat", i), dbus_dat_o, tbl[i].dout);
      chk($sformatf("vec%0d_we", i), dbus_we_o, tbl[i].we);
      chk($sformatf("vec%0d_wdata", i), wdata_o, tbl[i].wdata);
      chk($sformatf("vec%0d_mis", i), misalign_o, tbl[i].mis);
      chk($sformatf("vec%0d_cyc", i), dbus_cyc_o, !tbl[i].mis);
      chk($sformatf("vec%0d_adr", i), dbus_adr_o, tbl[i].mis ? 32'h0 : tbl[i].adr & 32'hFFFF_FFFC);
      chk($sformatf("vec%0d_stallreq", i), stallreq_o, 0);
      chk($sformatf("vec%0d_wreg", i), wreg_o, tbl[i].wr & !tbl[i].mis);
      step();
    end
    idle();

    drv(EXE_LW_OP, 32'h100, 0, 1, 32'h0); dbus_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lw_stallreq", stallreq_o, 1);
      chk("lw_cyc", dbus_cyc_o, 1);
      chk("lw_stb", dbus_stb_o, 1);
      chk("lw_adr", dbus_adr_o, 32'h100);
      chk("lw_sel", dbus_sel_o, 4'b1111);
      chk("lw_wreg_wait", wreg_o, 0);
      step();
    end
    dbus_ack_i = 1; dbus_dat_i = 32'hDEAD_BEEF;
    #2;
    chk("lw_ack_wdata", wdata_o, 32'hDEAD_BEEF);
    chk("lw_ack_wreg", wreg_o, 1);
    chk("lw_ack_stallreq", stallreq_o, 0);
    step();
    idle();

    drv(EXE_LH_OP, 32'h302, 0, 1, 32'h0); dbus_ack_i = 0; stall_i = 6'b01_1111;
    #2;
    chk("hold_wait_stallreq", stallreq_o, 1);
    step();
    dbus_ack_i = 1; dbus_dat_i = 32'h0000_9ABC;
    #2;
    chk("hold_ack_wdata", wdata_o, 32'hFFFF_9ABC);
    step();
    dbus_ack_i = 0; dbus_dat_i = 32'h5555_5555;
    #2;
    chk("hold_cyc", dbus_cyc_o, 0);
    chk("hold_stallreq", stallreq_o, 0);
    chk("hold_wdata", wdata_o, 32'hFFFF_9ABC);
    step();
    stall_i = 0;
    #2;
    chk("hold_rel_cyc", dbus_cyc_o, 0);
    chk("hold_rel_wdata", wdata_o, 32'hFFFF_9ABC);
    chk("hold_rel_wreg", wreg_o, 1);
    step();
    idle();

    drv(EXE_LW_OP, 32'h102, 0, 1, 32'h0); dbus_ack_i = 0;
    #2;
    chk("mis_flag", misalign_o, 1);
    chk("mis_cyc", dbus_cyc_o, 0);
    chk("mis_wreg", wreg_o, 0);
    chk("mis_stallreq", stallreq_o, 0);
    step();

    drv(EXE_LW_OP, 32'h400, 0, 1, 32'h0); dbus_ack_i = 0;
    #2;
    chk("fl_busy_stallreq", stallreq_o, 1);
    step();
    flush_i = 1; dbus_ack_i = 1; dbus_dat_i = 32'h7777_7777;
    #2;
    chk("fl_wreg", wreg_o, 0);
    step();
    drv(EXE_NOP_OP, 0, 0, 0, 0); flush_i = 0;
    #2;
    chk("fl_after_cyc", dbus_cyc_o, 0);
    chk("fl_after_wreg", wreg_o, 0);
    step();
    drv(EXE_LW_OP, 32'h500, 0, 1, 32'h0); dbus_dat_i = 32'h0000_0042;
    #2;
    chk("fl_idle_cyc", dbus_cyc_o, 1);
    chk("fl_idle_wdata", wdata_o, 32'h0000_0042);
    step();
    idle();

    drv(EXE_SW_OP, 32'h600, 32'h0BAD_F00D, 0, 32'h0); dbus_ack_i = 0;
    #2;
    chk("rb_busy_cyc", dbus_cyc_o, 1);
    step();
    rst = 1;
    #2;
    chk("rb_rst_cyc", dbus_cyc_o, 0);
    chk("rb_rst_stallreq", stallreq_o, 0);
    step();
    rst = 0; drv(EXE_NOP_OP, 0, 0, 0, 0); dbus_ack_i = 1;
    #2;
    chk("rb_late_ack_cyc", dbus_cyc_o, 0);
    chk("rb_late_ack_wreg", wreg_o, 0);
    step();
    drv(EXE_LBU_OP, 32'h701, 0, 1, 32'h0); dbus_dat_i = 32'h00C3_0000;
    #2;
    chk("rb_idle_cyc", dbus_cyc_o, 1);
    chk("rb_idle_wdata", wdata_o, 32'h0000_00C3);
    step();
    idle();

    for (int t = 0; t < 200; t++) begin
      pass = $urandom_range(0, 3) == 0;
      op = pass ? pops[$urandom_range(0, 3)] : mops[$urandom_range(0, 7)];
      adr = $urandom;
      if ($urandom_range(0, 1) == 1) adr[1:0] = 2'b00;
      r2 = $urandom; din = $urandom; wd = $urandom;
      ld = !pass && m_load_op(op);
      st = !pass && !ld;
      mis = !pass && m_mis(op, adr);
      hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom); wd_i = 5'($urandom);
      drv(op, adr, r2, ld | (pass & 1'($urandom)), wd);
      flush_i = 0;
      if (pass || mis) begin
        dbus_ack_i = 1'($urandom); stall_i = 0;
        #2;
        chk("rnd_pt_cyc", dbus_cyc_o, 0);
        chk("rnd_pt_stallreq", stallreq_o, 0);
        chk("rnd_pt_mis", misalign_o, mis);
        chk("rnd_pt_wreg", wreg_o, wreg_i & !mis);
        chk("rnd_pt_wdata", wdata_o, wd);
        chk("rnd_pt_hi", hi_o, hi_i);
        step();
      end else begin
        dly = $urandom_range(0, 3);
        hc = $urandom_range(0, 2);
        exp_w = ld ? m_load(op, adr, din) : wd;
        stall_i = hc > 0 ? 6'b01_1111 : 6'b0;
        dbus_ack_i = 0;
        for (int i = 0; i < dly; i++) begin
          dbus_dat_i = $urandom;
          #2;
          chk("rnd_wait_cyc", dbus_cyc_o, 1);
          chk("rnd_wait_stallreq", stallreq_o, 1);
          chk("rnd_wait_wreg", wreg_o, 0);
          chk("rnd_wait_adr", dbus_adr_o, adr & 32'hFFFF_FFFC);
          chk("rnd_wait_sel", dbus_sel_o, m_sel(op, adr));
          step();
        end
        dbus_ack_i = 1; dbus_dat_i = din;
        #2;
        chk("rnd_ack_cyc", dbus_cyc_o, 1);
        chk("rnd_ack_we", dbus_we_o, st);
        chk("rnd_ack_sel", dbus_sel_o, m_sel(op, adr));
        chk("rnd_ack_dat", dbus_dat_o, st ? m_sdat(op, r2) : 32'h0);
        chk("rnd_ack_stallreq", stallreq_o, 0);
        chk("rnd_ack_wdata", wdata_o, exp_w);
        chk("rnd_ack_wreg", wreg_o, ld);
        step();
        for (int h = 1; h <= hc; h++) begin
          dbus_ack_i = 0; dbus_dat_i = $urandom;
          stall_i = h < hc ? 6'b01_1111 : 6'b0;
          #2;
          chk("rnd_hold_cyc", dbus_cyc_o, 0);
          chk("rnd_hold_stallreq", stallreq_o, 0);
          chk("rnd_hold_wdata", wdata_o, exp_w);
          step();
        end
        stall_i = 0;
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_dbus_stage.md
Name: mem_dbus_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs and performs loads and stores over a single-master Wishbone-style data bus.
- Aligns load data and builds store byte-lanes. Holds the pipeline via stallreq_o until the bus acknowledges.
- Forwards the write-back and HI/LO fields to the MEM/WB register.

Parameters:
- none. Opcode encodings and widths come from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  6  stall vector from the stall controller; bit 4 = MEM/WB hold
- flush_i  in  1  pipeline flush
- wd_i  in  5  destination register address
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result
- hi_i  in  32  HI value
- lo_i  in  32  LO value
- whilo_i  in  1  HI/LO write enable
- aluop_i  in  8  operation code
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store source data
- dbus_dat_i  in  32  bus read data
- dbus_ack_i  in  1  bus acknowledge
- dbus_adr_o  out  32  bus address, word-aligned
- dbus_dat_o  out  32  bus write data
- dbus_we_o  out  1  bus write enable
- dbus_sel_o  out  4  byte lane selects
- dbus_stb_o  out  1  bus strobe
- dbus_cyc_o  out  1  bus cycle
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- hi_o  out  32  to MEM/WB
- lo_o  out  32  to MEM/WB
- whilo_o  out  1  to MEM/WB
- stallreq_o  out  1  stall request to the stall controller
- misalign_o  out  1  misaligned-access flag, valid for one cycle per offending op

Behaviour:
- Reset: FSM to IDLE. All outputs forced to 0, with wd_o = 5'b0.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Any other aluop passes wd/wreg/wdata/hi/lo/whilo straight through (combinational) with no bus activity.
- Byte order is big-endian. Byte at addr[1:0]=0 lives in dat[31:24], sel 4'b1000.
  - Halfword: addr[1]=0 uses sel 4'b1100; addr[1]=1 uses sel 4'b0011.
  - Word: sel 4'b1111.
- dbus_adr_o = {mem_addr_i[31:2], 2'b00}.
- Store data is replicated to every lane: SB -> {4{b}}, SH -> {2{h}}.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0:
  - misalign_o=1, no bus cycle, wreg_o=0.
  - No stall request.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: an aligned memory op asserts cyc/stb/we/sel/adr/dat in the same cycle, sets stallreq_o=1, and registers the transition to BUSY.
    - If dbus_ack_i is already 1 in that same cycle, the op completes combinationally and stays in IDLE, same as the BUSY completion rule.
  - BUSY: cyc/stb held stable with stallreq_o=1 until dbus_ack_i.
    - On ack: capture dbus_dat_i into the rdata register; deassert cyc/stb next cycle.
    - If stall_i[4]=0 on ack: stallreq_o=0 in the ack cycle; go to IDLE.
    - Else: go to HOLD.
  - HOLD: bus idle, stallreq_o=0. Outputs taken from the captured rdata. Return to IDLE when stall_i[4]=0.
- Load result, zero/sign-extended per op from the bus data (ack cycle) or captured data (HOLD). LB at addr 2 of 0x1122_8344 gives 0xFFFF_FF83; LBU gives 0x0000_0083.
- While stallreq_o=1, wreg_o=0 so no partial write-back occurs.
- Flush:
  - In BUSY: drop cyc/stb next cycle, go to IDLE, discard data, wreg_o=0.
  - In HOLD: go to IDLE.
  - flush_i outranks ack in the same cycle.
- rst mid-access: immediate return to IDLE, bus released the same edge.
- Stores never write the register file: wreg_o passes wreg_i, which is 0 for stores.

Decomposition:
- Shared package holds:
  - aluop constants EXE_LB_OP … EXE_SW_OP and EXE_NOP_OP
  - widths RegBus (32), RegAddrBus (5), AluOpBus (8)
  - Stop/NoStop, WriteEnable/WriteDisable
  - FSM state encoding
- One sub-module, mem_lane_align: combinational sel/store-data builder and load extractor/extender. The FSM stays in the top block.

Test Plan:
- Pass-through: aluop ADD, wdata=0x1234_5678, wd=3, wreg=1 -> same cycle wdata_o=0x1234_5678, wreg_o=1, no cyc.
- LW at 0x100, slave acks after 3 cycles with 0xDEAD_BEEF:
  - stallreq_o=1 for 3 cycles, adr=0x100, sel=4'b1111.
  - In the ack cycle, wdata_o=0xDEAD_BEEF and wreg_o=1, and stallreq_o drops to 0 in that same cycle.
- SB 0xA5 at 0x203 -> sel=4'b0001, dat_o=0xA5A5_A5A5, we=1. LH at 0x202 returning 0x0000_8001 -> wdata_o=0xFFFF_8001.
- Ack while stall_i[4]=1 for 2 cycles:
  - HOLD entered; cyc drops.
  - rdata held; wdata_o correct when the stall releases; no second bus cycle.
- Misaligned LW at 0x102 -> misalign_o=1, cyc=0, wreg_o=0, stallreq_o=0.
- flush_i during BUSY, and rst during BUSY -> cyc/stb=0 next edge, FSM IDLE, wreg_o=0. A later ack is ignored.
